mc_control_fsm: RTL and testbench
=================================

MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15, meaning max wait cycles for mem_ready before trap (1..255).
REQ-002 SHALL have parameter RET_W, default 32, meaning width of the retired-instruction counter.
REQ-003 SHALL have port clk, input, 1, meaning the single clock (all state on rising edge).
REQ-004 SHALL have port rst_n, input, 1, meaning the asynchronous active-low reset.
REQ-005 SHALL have ports opcode/funct3, input, 7/3, meaning fields of the latched instruction register.
REQ-006 SHALL have ports zero/lt/ltu, input, 1 each, meaning ALU equal, signed-less and unsigned-less flags.
REQ-007 SHALL have port mem_ready, input, 1, meaning the memory has completed the current read/write this cycle.
REQ-008 SHALL have ports pc_write/ir_write/mem_read/mem_write/reg_write/adr_src, output, 1 each, meaning datapath strobes and selects.
REQ-009 SHALL have ports alu_src_a/alu_src_b/aluop/result_src, output, 2 each; port immsrc, output, 3; meaning datapath mux and ALU controls.
REQ-010 SHALL have ports halt (1), trap_cause (2), state_o (4), retired (RET_W), all outputs, meaning trap flag, trap reason, current state, and count of completed instructions.

Function
REQ-011 SHALL implement states IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH, JAL, JALR, UPPER, TRAP; state_o SHALL carry the encoding 0..14 in that order.
REQ-012 SHALL make outputs a Moore decode of the state, except pc_write/ir_write/reg_write, which may also depend on mem_ready or the flags as stated below.
REQ-013 SHALL move IDLE->FETCH unconditionally; IDLE drives every output 0.
REQ-014 In FETCH: mem_read=1, adr_src=0, alu_src_a=00, alu_src_b=10, aluop=00; pc_write=ir_write=mem_ready; on mem_ready go to DECODE, else stay.
REQ-015 DECODE SHALL dispatch on opcode: 0000011/0100011->MEMADR, 0110011->EXECR, 0010011->EXECI, 1100011->BRANCH, 1101111->JAL, 1100111->JALR, 0110111/0010111->UPPER (macro only), any other->TRAP with cause 01.
REQ-016 MEMADR SHALL drive immsrc=000 (load) or 001 (store) and go to MEMRD (load) or MEMWR (store); MEMRD/MEMWR SHALL hold until mem_ready.
REQ-017 MEMRD on mem_ready SHALL go to MEMWB; MEMWB SHALL assert reg_write with result_src=01 for one cycle, then go to FETCH.
REQ-018 EXECR (aluop=10, alu_src_b=00) and EXECI (aluop=10, alu_src_b=01, immsrc=000) SHALL go to ALUWB; ALUWB SHALL assert reg_write with result_src=00, then go to FETCH.
REQ-019 BRANCH SHALL drive aluop=01 and immsrc=010, and assert pc_write iff funct3 condition holds (000 zero, 001 !zero, 100 lt, 101 !lt, 110 ltu, 111 !ltu); funct3 010/011 SHALL go to TRAP with cause 10; otherwise -> FETCH.
REQ-020 JAL (immsrc=011) and JALR (immsrc=000) SHALL assert pc_write and reg_write with result_src=10 in one cycle, then go to FETCH.
REQ-021 SHALL count consecutive cycles in FETCH/MEMRD/MEMWR without mem_ready; on reaching MEM_TIMEOUT SHALL go to TRAP with cause 11; the counter SHALL clear on mem_ready or state change.
REQ-022 TRAP SHALL be absorbing: halt=1, trap_cause held, all strobes 0, until reset.
REQ-023 retired SHALL increment by 1 (wrapping modulo 2^RET_W) on every transition into FETCH from a non-IDLE, non-TRAP state.
REQ-024 mem_ready asserted in a non-memory state SHALL be ignored.

Reset
REQ-025 rst_n low SHALL asynchronously force state IDLE, timeout counter 0, retired 0, trap_cause 00, halt 0, all strobes 0; assertion mid-transaction SHALL abort it with no strobe on the following edge.

Configuration
REQ-026 With CTRL_UPPER_EN defined, LUI/AUIPC SHALL enter UPPER (immsrc=100, alu_src_a=01 for LUI (zero) or 00 for AUIPC (pc), result_src=11, reg_write=1) then FETCH; without it, both opcodes SHALL trap with cause 01.

Verification
REQ-027 Reset then add (0110011), mem_ready=1 always -> states 0,1,2,7,9,1; reg_write high exactly one cycle; retired=1.
REQ-028 lw with mem_ready held low 3 cycles in MEMRD -> MEMRD held 4 cycles, then MEMWB reg_write result_src=01; retired=1.
REQ-029 beq with zero=1 then bne with zero=1 -> pc_write=1 in first BRANCH cycle, 0 in second; retired=2.
REQ-030 mem_ready held low for 15 cycles in FETCH (MEM_TIMEOUT=15) -> TRAP, halt=1, trap_cause=11, persists until rst_n low.
REQ-031 Opcode 0110111 -> UPPER with reg_write when CTRL_UPPER_EN defined; TRAP cause 01 when not; rst_n pulse low mid-MEMWR returns to IDLE with mem_write=0.

Source files
------------

// File: rtl/mc_control_fsm_if.sv
// Control bundle between the multicycle controller and its datapath.
// master = controller side (drives strobes), slave = datapath side (drives IR fields, flags, mem_ready).
interface mc_control_fsm_if #(
  parameter int RET_W = 32
);
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic             zero;
  logic             lt;
  logic             ltu;
  logic             mem_ready;

  logic             pc_write;
  logic             ir_write;
  logic             mem_read;
  logic             mem_write;
  logic             reg_write;
  logic             adr_src;
  logic [1:0]       alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       aluop;
  logic [1:0]       result_src;
  logic [2:0]       immsrc;
  logic             halt;
  logic [1:0]       trap_cause;
  logic [3:0]       state_o;
  logic [RET_W-1:0] retired;

  modport master (
    input  opcode, funct3, zero, lt, ltu, mem_ready,
    output pc_write, ir_write, mem_read, mem_write, reg_write, adr_src,
           alu_src_a, alu_src_b, aluop, result_src, immsrc,
           halt, trap_cause, state_o, retired
  );

  modport slave (
    output opcode, funct3, zero, lt, ltu, mem_ready,
    input  pc_write, ir_write, mem_read, mem_write, reg_write, adr_src,
           alu_src_a, alu_src_b, aluop, result_src, immsrc,
           halt, trap_cause, state_o, retired
  );
endinterface

// File: rtl/mc_control_fsm.sv
// Multicycle RV32 control FSM with memory timeout trap and retire counter; CTRL_UPPER_EN adds LUI/AUIPC.
// Strobes registered one cycle after the state decision; mem_ready stalls FETCH/MEMRD/MEMWR, trapping after MEM_TIMEOUT misses.
module mc_control_fsm #(
  parameter int MEM_TIMEOUT = 15,
  parameter int RET_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  mc_control_fsm_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXECR  = 4'd7,
    S_EXECI  = 4'd8,
    S_ALUWB  = 4'd9,
    S_BRANCH = 4'd10,
    S_JAL    = 4'd11,
    S_JALR   = 4'd12,
    S_UPPER  = 4'd13,
    S_TRAP   = 4'd14
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       adr_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] aluop;
    logic [1:0] result_src;
    logic [2:0] immsrc;
    logic       halt;
  } ctrl_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
`ifdef CTRL_UPPER_EN
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
`endif

  localparam logic [1:0] CAUSE_ILL = 2'b01;
  localparam logic [1:0] CAUSE_BR  = 2'b10;
  localparam logic [1:0] CAUSE_TO  = 2'b11;
  localparam logic [7:0] TO_LAST   = 8'(MEM_TIMEOUT - 1);

  state_t           r_state;
  ctrl_t            r_ctrl;
  logic [7:0]       r_to_cnt;
  logic [1:0]       r_trap_cause;
  logic [RET_W-1:0] r_retired;

  state_t           w_nxt;
  logic [1:0]       w_cause;
  logic             w_wait_state;
  logic             w_to_hit;
  logic             w_br_cond;
  logic             w_br_bad;
  logic             w_fetch_done;

  // Moore strobe set for a given state; the IR is stable outside FETCH so op is safe to use here.
  function automatic ctrl_t f_decode(state_t s, logic [6:0] op);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:  begin c.mem_read = 1'b1; c.alu_src_b = 2'b10; end
      S_MEMADR: c.immsrc = (op == OP_STORE) ? 3'b001 : 3'b000;
      S_MEMRD:  begin c.mem_read = 1'b1; c.adr_src = 1'b1; end
      S_MEMWB:  begin c.reg_write = 1'b1; c.result_src = 2'b01; end
      S_MEMWR:  begin c.mem_write = 1'b1; c.adr_src = 1'b1; end
      S_EXECR:  begin c.aluop = 2'b10; c.alu_src_b = 2'b00; end
      S_EXECI:  begin c.aluop = 2'b10; c.alu_src_b = 2'b01; c.immsrc = 3'b000; end
      S_ALUWB:  begin c.reg_write = 1'b1; c.result_src = 2'b00; end
      S_BRANCH: begin c.aluop = 2'b01; c.immsrc = 3'b010; end
      S_JAL: begin
        c.immsrc = 3'b011; c.pc_write = 1'b1; c.reg_write = 1'b1; c.result_src = 2'b10;
      end
      S_JALR: begin
        c.immsrc = 3'b000; c.pc_write = 1'b1; c.reg_write = 1'b1; c.result_src = 2'b10;
      end
      S_UPPER: begin
        c.immsrc     = 3'b100;
        c.alu_src_a  = (op == OP_LUI) ? 2'b01 : 2'b00;
        c.result_src = 2'b11;
        c.reg_write  = 1'b1;
      end
      S_TRAP:   c.halt = 1'b1;
      default:  c = '0;
    endcase
    return c;
  endfunction

  assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
  assign w_to_hit     = (r_to_cnt == TO_LAST);
  assign w_fetch_done = (r_state == S_FETCH) && bus.mem_ready;
  assign w_br_bad     = (bus.funct3 == 3'b010) || (bus.funct3 == 3'b011);

  always_comb begin
    w_br_cond = 1'b0;
    case (bus.funct3)
      3'b000:  w_br_cond = bus.zero;
      3'b001:  w_br_cond = !bus.zero;
      3'b100:  w_br_cond = bus.lt;
      3'b101:  w_br_cond = !bus.lt;
      3'b110:  w_br_cond = bus.ltu;
      3'b111:  w_br_cond = !bus.ltu;
      default: w_br_cond = 1'b0;
    endcase
  end

  always_comb begin
    w_nxt   = r_state;
    w_cause = r_trap_cause;
    case (r_state)
      S_IDLE:   w_nxt = S_FETCH;
      S_FETCH: begin
        if (bus.mem_ready)  w_nxt = S_DECODE;
        else if (w_to_hit) begin w_nxt = S_TRAP; w_cause = CAUSE_TO; end
      end
      S_DECODE: begin
        case (bus.opcode)
          OP_LOAD, OP_STORE: w_nxt = S_MEMADR;
          OP_R:              w_nxt = S_EXECR;
          OP_I:              w_nxt = S_EXECI;
          OP_BR:             w_nxt = S_BRANCH;
          OP_JAL:            w_nxt = S_JAL;
          OP_JALR:           w_nxt = S_JALR;
`ifdef CTRL_UPPER_EN
          OP_LUI, OP_AUIPC:  w_nxt = S_UPPER;
`endif
          default: begin w_nxt = S_TRAP; w_cause = CAUSE_ILL; end
        endcase
      end
      S_MEMADR: w_nxt = (bus.opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
      S_MEMRD: begin
        if (bus.mem_ready)  w_nxt = S_MEMWB;
        else if (w_to_hit) begin w_nxt = S_TRAP; w_cause = CAUSE_TO; end
      end
      S_MEMWR: begin
        if (bus.mem_ready)  w_nxt = S_FETCH;
        else if (w_to_hit) begin w_nxt = S_TRAP; w_cause = CAUSE_TO; end
      end
      S_EXECR, S_EXECI: w_nxt = S_ALUWB;
      S_BRANCH: begin
        if (w_br_bad) begin w_nxt = S_TRAP; w_cause = CAUSE_BR; end
        else               w_nxt = S_FETCH;
      end
      S_MEMWB, S_ALUWB, S_JAL, S_JALR, S_UPPER: w_nxt = S_FETCH;
      S_TRAP:   w_nxt = S_TRAP;
      default:  w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_ctrl       <= '0;
      r_to_cnt     <= '0;
      r_trap_cause <= 2'b00;
      r_retired    <= '0;
    end else begin
      r_state      <= w_nxt;
      r_ctrl       <= f_decode(w_nxt, bus.opcode);
      r_trap_cause <= w_cause;
      // Counts only consecutive misses within one wait state.
      if ((w_nxt != r_state) || bus.mem_ready || !w_wait_state)
        r_to_cnt <= '0;
      else
        r_to_cnt <= r_to_cnt + 8'd1;
      if ((w_nxt == S_FETCH) && (r_state != S_FETCH) &&
          (r_state != S_IDLE) && (r_state != S_TRAP))
        r_retired <= r_retired + RET_W'(1);
    end
  end

  // FETCH handshake and branch outcome are the only same-cycle strobes.
  assign bus.pc_write   = r_ctrl.pc_write | w_fetch_done | ((r_state == S_BRANCH) && w_br_cond);
  assign bus.ir_write   = w_fetch_done;
  assign bus.mem_read   = r_ctrl.mem_read;
  assign bus.mem_write  = r_ctrl.mem_write;
  assign bus.reg_write  = r_ctrl.reg_write;
  assign bus.adr_src    = r_ctrl.adr_src;
  assign bus.alu_src_a  = r_ctrl.alu_src_a;
  assign bus.alu_src_b  = r_ctrl.alu_src_b;
  assign bus.aluop      = r_ctrl.aluop;
  assign bus.result_src = r_ctrl.result_src;
  assign bus.immsrc     = r_ctrl.immsrc;
  assign bus.halt       = r_ctrl.halt;
  assign bus.trap_cause = r_trap_cause;
  assign bus.state_o    = r_state;
  assign bus.retired    = r_retired;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: decode vector table, directed corner sequences, random instruction stream.
// Expected state paths are built per instruction class; RET_W=4 so the retire counter wraps.
module tb_mc_control_fsm;
  localparam int RW = 4;
  localparam int TO = 15;

  localparam logic [3:0] IDLE = 4'd0, FETCH = 4'd1, DECODE = 4'd2, MEMADR = 4'd3;
  localparam logic [3:0] MEMRD = 4'd4, MEMWB = 4'd5, MEMWR = 4'd6, EXECR = 4'd7;
  localparam logic [3:0] EXECI = 4'd8, ALUWB = 4'd9, BRANCH = 4'd10, JAL = 4'd11;
  localparam logic [3:0] JALR = 4'd12, UPPER = 4'd13, TRAP = 4'd14;

  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;

  typedef struct {
    logic [3:0] st;
    logic       rdy;
    logic       pcw;
    logic       regw;
    logic       memw;
    logic [1:0] rs;
  } step_t;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       z, l, lu;
    logic [3:0] st1;
    logic       ci;
    logic [2:0] imm;
    logic       pcw;
    logic [3:0] st2;
    logic [1:0] cause;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  int model_ret = 0;
  step_t plan[$];
  vec_t tbl[$];

  mc_control_fsm_if #(.RET_W(RW)) bus();

  mc_control_fsm #(.MEM_TIMEOUT(TO), .RET_W(RW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached checks=%0d", checks);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [31:0] strobes();
    return 32'({bus.pc_write, bus.ir_write, bus.mem_read, bus.mem_write, bus.reg_write,
                bus.adr_src, bus.alu_src_a, bus.alu_src_b, bus.aluop, bus.result_src, bus.immsrc});
  endfunction

  function automatic logic br_taken(logic [2:0] f3, logic z, logic l, logic lu);
    case (f3)
      3'b000:  return z;
      3'b001:  return !z;
      3'b100:  return l;
      3'b101:  return !l;
      3'b110:  return lu;
      3'b111:  return !lu;
      default: return 1'b0;
    endcase
  endfunction

  // Leaves the DUT in its first FETCH cycle, one step after an edge.
  task automatic do_reset();
    rst_n = 1'b0;
    bus.mem_ready = 1'b0;
    #1;
    chk("rst_state", 32'(bus.state_o), 32'(IDLE));
    chk("rst_halt", 32'(bus.halt), 0);
    chk("rst_cause", 32'(bus.trap_cause), 0);
    chk("rst_retired", 32'(bus.retired), 0);
    chk("rst_strobes", strobes(), 0);
    tick();
    rst_n = 1'b1;
    model_ret = 0;
    #1;
    chk("idle_strobes", strobes(), 0);
    tick();
    chk("fetch_entry", 32'(bus.state_o), 32'(FETCH));
  endtask

  task automatic add_step(logic [3:0] st, logic rdy, logic pcw, logic regw, logic memw, logic [1:0] rs);
    step_t s;
    s.st = st; s.rdy = rdy; s.pcw = pcw; s.regw = regw; s.memw = memw; s.rs = rs;
    plan.push_back(s);
  endtask

  // Runs one instruction from FETCH back to FETCH with fst fetch misses and mst memory misses.
  task automatic exec_instr(input logic [6:0] op, input logic [2:0] f3, input logic z, input logic l,
                            input logic lu, input int fst, input int mst);
    plan.delete();
    for (int i = 0; i < fst; i++) add_step(FETCH, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    add_step(FETCH, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00);
    add_step(DECODE, rb(), 1'b0, 1'b0, 1'b0, 2'b00);
    case (op)
      OP_LOAD: begin
        add_step(MEMADR, rb(), 1'b0, 1'b0, 1'b0, 2'b00);
        for (int i = 0; i < mst; i++) add_step(MEMRD, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        add_step(MEMRD, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
        add_step(MEMWB, rb(), 1'b0, 1'b1, 1'b0, 2'b01);
      end
      OP_STORE: begin
        add_step(MEMADR, rb(), 1'b0, 1'b0, 1'b0, 2'b00);
        for (int i = 0; i < mst; i++) add_step(MEMWR, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
        add_step(MEMWR, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00);
      end
      OP_R: begin
        add_step(EXECR, rb(), 1'b0, 1'b0, 1'b0, 2'b00);
        add_step(ALUWB, rb(), 1'b0, 1'b1, 1'b0, 2'b00);
      end
      OP_I: begin
        add_step(EXECI, rb(), 1'b0, 1'b0, 1'b0, 2'b00);
        add_step(ALUWB, rb(), 1'b0, 1'b1, 1'b0, 2'b00);
      end
      OP_BR:   add_step(BRANCH, rb(), br_taken(f3, z, l, lu), 1'b0, 1'b0, 2'b00);
      OP_JAL:  add_step(JAL, rb(), 1'b1, 1'b1, 1'b0, 2'b10);
      OP_JALR: add_step(JALR, rb(), 1'b1, 1'b1, 1'b0, 2'b10);
      default: add_step(UPPER, rb(), 1'b0, 1'b1, 1'b0, 2'b11);
    endcase
    bus.opcode = op; bus.funct3 = f3; bus.zero = z; bus.lt = l; bus.ltu = lu;
    foreach (plan[i]) begin
      bus.mem_ready = plan[i].rdy;
      #1;
      chk($sformatf("op%0h_state%0d", op, i), 32'(bus.state_o), 32'(plan[i].st));
      chk($sformatf("op%0h_pcw%0d", op, i), 32'(bus.pc_write), 32'(plan[i].pcw));
      chk($sformatf("op%0h_regw%0d", op, i), 32'(bus.reg_write), 32'(plan[i].regw));
      chk($sformatf("op%0h_memw%0d", op, i), 32'(bus.mem_write), 32'(plan[i].memw));
      if (plan[i].regw) chk($sformatf("op%0h_rsrc%0d", op, i), 32'(bus.result_src), 32'(plan[i].rs));
      tick();
    end
    model_ret = (model_ret + 1) % (1 << RW);
    chk("retire_state", 32'(bus.state_o), 32'(FETCH));
    chk("retired", 32'(bus.retired), 32'(model_ret));
  endtask

  task automatic add_vec(logic [6:0] op, logic [2:0] f3, logic z, logic l, logic lu, logic [3:0] st1,
                         logic ci, logic [2:0] imm, logic pcw, logic [3:0] st2, logic [1:0] cause);
    vec_t v;
    v.op = op; v.f3 = f3; v.z = z; v.l = l; v.lu = lu; v.st1 = st1; v.ci = ci;
    v.imm = imm; v.pcw = pcw; v.st2 = st2; v.cause = cause;
    tbl.push_back(v);
  endtask

  initial begin
    logic [6:0] op;
    logic [2:0] f3;
    logic [2:0] bf3 [6];
    int k;

    bus.opcode = 7'd0; bus.funct3 = 3'd0; bus.zero = 1'b0; bus.lt = 1'b0; bus.ltu = 1'b0;
    bus.mem_ready = 1'b0;
    bf3[0] = 3'b000; bf3[1] = 3'b001; bf3[2] = 3'b100;
    bf3[3] = 3'b101; bf3[4] = 3'b110; bf3[5] = 3'b111;

    //      op        f3      z     l     lu    st1     ci    imm     pcw   st2     cause
    add_vec(OP_R,     3'b000, 1'b0, 1'b0, 1'b0, EXECR,  1'b0, 3'b000, 1'b0, ALUWB,  2'b00);
    add_vec(OP_I,     3'b000, 1'b0, 1'b0, 1'b0, EXECI,  1'b1, 3'b000, 1'b0, ALUWB,  2'b00);
    add_vec(OP_LOAD,  3'b010, 1'b0, 1'b0, 1'b0, MEMADR, 1'b1, 3'b000, 1'b0, MEMRD,  2'b00);
    add_vec(OP_STORE, 3'b010, 1'b0, 1'b0, 1'b0, MEMADR, 1'b1, 3'b001, 1'b0, MEMWR,  2'b00);
    add_vec(OP_JAL,   3'b000, 1'b0, 1'b0, 1'b0, JAL,    1'b1, 3'b011, 1'b1, FETCH,  2'b00);
    add_vec(OP_JALR,  3'b000, 1'b0, 1'b0, 1'b0, JALR,   1'b1, 3'b000, 1'b1, FETCH,  2'b00);
    add_vec(OP_BR,    3'b000, 1'b1, 1'b0, 1'b0, BRANCH, 1'b1, 3'b010, 1'b1, FETCH,  2'b00);
    add_vec(OP_BR,    3'b001, 1'b1, 1'b0, 1'b0, BRANCH, 1'b1, 3'b010, 1'b0, FETCH,  2'b00);
    add_vec(OP_BR,    3'b100, 1'b0, 1'b1, 1'b0, BRANCH, 1'b1, 3'b010, 1'b1, FETCH,  2'b00);
    add_vec(OP_BR,    3'b101, 1'b0, 1'b1, 1'b0, BRANCH, 1'b1, 3'b010, 1'b0, FETCH,  2'b00);
    add_vec(OP_BR,    3'b110, 1'b0, 1'b1, 1'b0, BRANCH, 1'b1, 3'b010, 1'b0, FETCH,  2'b00);
    add_vec(OP_BR,    3'b111, 1'b0, 1'b1, 1'b0, BRANCH, 1'b1, 3'b010, 1'b1, FETCH,  2'b00);
    add_vec(OP_BR,    3'b010, 1'b1, 1'b1, 1'b1, BRANCH, 1'b1, 3'b010, 1'b0, TRAP,   2'b10);
    add_vec(OP_BR,    3'b011, 1'b1, 1'b1, 1'b1, BRANCH, 1'b1, 3'b010, 1'b0, TRAP,   2'b10);
    add_vec(7'b0000000, 3'b000, 1'b0, 1'b0, 1'b0, TRAP, 1'b0, 3'b000, 1'b0, TRAP,   2'b01);
    add_vec(7'b1111111, 3'b000, 1'b0, 1'b0, 1'b0, TRAP, 1'b0, 3'b000, 1'b0, TRAP,   2'b01);
`ifdef CTRL_UPPER_EN
    add_vec(OP_LUI,   3'b000, 1'b0, 1'b0, 1'b0, UPPER,  1'b1, 3'b100, 1'b0, FETCH,  2'b00);
    add_vec(OP_AUIPC, 3'b000, 1'b0, 1'b0, 1'b0, UPPER,  1'b1, 3'b100, 1'b0, FETCH,  2'b00);
`else
    add_vec(OP_LUI,   3'b000, 1'b0, 1'b0, 1'b0, TRAP,   1'b0, 3'b000, 1'b0, TRAP,   2'b01);
    add_vec(OP_AUIPC, 3'b000, 1'b0, 1'b0, 1'b0, TRAP,   1'b0, 3'b000, 1'b0, TRAP,   2'b01);
`endif

    // add, lw with three MEMRD misses, beq/bne with zero set
    do_reset();
    exec_instr(OP_R, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0);
    do_reset();
    exec_instr(OP_LOAD, 3'b010, 1'b0, 1'b0, 1'b0, 0, 3);
    do_reset();
    exec_instr(OP_BR, 3'b000, 1'b1, 1'b0, 1'b0, 0, 0);
    exec_instr(OP_BR, 3'b001, 1'b1, 1'b0, 1'b0, 0, 0);

    foreach (tbl[i]) begin
      do_reset();
      bus.opcode = tbl[i].op; bus.funct3 = tbl[i].f3;
      bus.zero = tbl[i].z; bus.lt = tbl[i].l; bus.ltu = tbl[i].lu;
      bus.mem_ready = 1'b1;
      tick();
      bus.mem_ready = 1'b0;
      tick();
      chk($sformatf("tbl%0d_state", i), 32'(bus.state_o), 32'(tbl[i].st1));
      if (tbl[i].ci) chk($sformatf("tbl%0d_imm", i), 32'(bus.immsrc), 32'(tbl[i].imm));
      chk($sformatf("tbl%0d_pcw", i), 32'(bus.pc_write), 32'(tbl[i].pcw));
      tick();
      chk($sformatf("tbl%0d_next", i), 32'(bus.state_o), 32'(tbl[i].st2));
      chk($sformatf("tbl%0d_cause", i), 32'(bus.trap_cause), 32'(tbl[i].cause));
      chk($sformatf("tbl%0d_halt", i), 32'(bus.halt), 32'(tbl[i].st2 == TRAP));
    end

    // Fetch timeout: 14 misses keep waiting, the 15th traps; the trap then absorbs everything.
    do_reset();
    bus.mem_ready = 1'b0;
    for (int i = 0; i < TO - 1; i++) tick();
    chk("to_still_fetch", 32'(bus.state_o), 32'(FETCH));
    tick();
    chk("to_state", 32'(bus.state_o), 32'(TRAP));
    chk("to_halt", 32'(bus.halt), 1);
    chk("to_cause", 32'(bus.trap_cause), 32'(2'b11));
    for (int i = 0; i < 6; i++) begin
      bus.mem_ready = rb();
      bus.opcode = 7'($urandom);
      #1;
      chk("trap_hold_state", 32'(bus.state_o), 32'(TRAP));
      chk("trap_hold_cause", 32'(bus.trap_cause), 32'(2'b11));
      chk("trap_hold_strobes", strobes(), 0);
      chk("trap_hold_ret", 32'(bus.retired), 0);
      tick();
    end

    // Reset pulse in the middle of a store.
    do_reset();
    bus.opcode = OP_STORE;
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
    tick();
    tick();
    chk("memwr_state", 32'(bus.state_o), 32'(MEMWR));
    chk("memwr_strobe", 32'(bus.mem_write), 1);
    tick();
    rst_n = 1'b0;
    #1;
    chk("abort_state", 32'(bus.state_o), 32'(IDLE));
    chk("abort_memw", 32'(bus.mem_write), 0);
    tick();
    chk("abort_edge_state", 32'(bus.state_o), 32'(IDLE));
    chk("abort_edge_strobes", strobes(), 0);
    rst_n = 1'b1;

    // Random instruction stream; more than 16 retirements wraps the 4-bit counter.
    do_reset();
    for (int n = 0; n < 40; n++) begin
`ifdef CTRL_UPPER_EN
      k = $urandom_range(0, 8);
`else
      k = $urandom_range(0, 7);
`endif
      case (k)
        0: op = OP_LOAD;
        1: op = OP_STORE;
        2: op = OP_R;
        3: op = OP_I;
        4, 5: op = OP_BR;
        6: op = OP_JAL;
        7: op = OP_JALR;
        default: op = rb() ? OP_LUI : OP_AUIPC;
      endcase
      f3 = (op == OP_BR) ? bf3[$urandom_range(0, 5)] : 3'($urandom);
      exec_instr(op, f3, rb(), rb(), rb(), $urandom_range(0, TO - 1), $urandom_range(0, TO - 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
